// File: rtl/switch_input_conditioner.sv
// Synchronizes and debounces four switches plus a step key and drives a clean registered A/B/C/D vector.
// Define SWITCH_SWEEP_EN to add the MANUAL/SWEEP/DONE truth-table sweep; without it the block is manual-only.
module switch_input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int STEP_CYCLES     = 25000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] sw_in,
   input  logic       key_step_n,
   input  logic       mode,
   output logic [3:0] abcd_out,
   output logic       abcd_valid,
   output logic       sweep_done
);

`ifdef SWITCH_SWEEP_EN
   localparam int NIN = 5;
   logic [NIN-1:0] raw;
   assign raw = {key_step_n, sw_in};
`else
   localparam int NIN = 4;
   logic [NIN-1:0] raw;
   assign raw = sw_in;
   logic unused_inputs;
   assign unused_inputs = &{1'b0, mode, key_step_n};
`endif

   // Idle level of each input: switches rest low, the active-low key rests high.
   localparam logic [4:0] IDLE_LEVEL = 5'b10000;
   localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [NIN-1:0] stable;
   logic [3:0]     sw_stable;
   logic [3:0]     sw_prev_reg;
   logic [3:0]     out_reg;
   logic           valid_reg;
   logic           sw_changed;

   genvar gi;
   generate
      for (gi = 0; gi < NIN; gi++) begin : g_deb
         logic          sync1_reg;
         logic          sync2_reg;
         logic          stable_reg;
         logic [CW-1:0] cnt_reg;

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               sync1_reg  <= IDLE_LEVEL[gi];
               sync2_reg  <= IDLE_LEVEL[gi];
               stable_reg <= IDLE_LEVEL[gi];
               cnt_reg    <= '0;
            end else begin
               sync1_reg <= raw[gi];
               sync2_reg <= sync1_reg;
               if (sync2_reg == stable_reg) begin
                  cnt_reg <= '0;
               end else if (cnt_reg == DB_LAST) begin
                  stable_reg <= sync2_reg;
                  cnt_reg    <= '0;
               end else begin
                  cnt_reg <= cnt_reg + CW'(1);
               end
            end
         end

         assign stable[gi] = stable_reg;
      end
   endgenerate

   assign sw_stable  = stable[3:0];
   assign sw_changed = (sw_stable != sw_prev_reg);
   assign abcd_out   = out_reg;
   assign abcd_valid = valid_reg;

`ifdef SWITCH_SWEEP_EN
   typedef enum logic [1:0] {S_MANUAL, S_SWEEP, S_DONE} state_t;

   localparam int TW = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
   localparam logic [TW-1:0] STEP_LAST = TW'(STEP_CYCLES - 1);

   state_t        state_reg;
   logic          entry_reg;
   logic [TW-1:0] timer_reg;
   logic          key_prev_reg;
   logic          done_reg;
   logic          key_press;

   // A press is the debounced key falling; release is not an event.
   assign key_press  = key_prev_reg & ~stable[4];
   assign sweep_done = done_reg;

   // entry_reg defers a state's entry action to the edge after the transition.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg    <= S_MANUAL;
         entry_reg    <= 1'b0;
         timer_reg    <= '0;
         key_prev_reg <= 1'b1;
         sw_prev_reg  <= '0;
         out_reg      <= '0;
         valid_reg    <= 1'b0;
         done_reg     <= 1'b0;
      end else begin
         key_prev_reg <= stable[4];
         sw_prev_reg  <= sw_stable;
         valid_reg    <= 1'b0;
         case (state_reg)
            S_MANUAL: begin
               if (mode) begin
                  state_reg <= S_SWEEP;
                  entry_reg <= 1'b1;
               end else if (entry_reg || sw_changed) begin
                  out_reg   <= sw_stable;
                  valid_reg <= 1'b1;
                  entry_reg <= 1'b0;
               end
            end
            S_SWEEP: begin
               if (!mode) begin
                  state_reg <= S_MANUAL;
                  entry_reg <= 1'b1;
               end else if (entry_reg) begin
                  out_reg   <= '0;
                  valid_reg <= 1'b1;
                  timer_reg <= '0;
                  entry_reg <= 1'b0;
               end else if ((timer_reg == STEP_LAST) || key_press) begin
                  timer_reg <= '0;
                  if (out_reg == 4'hF) begin
                     state_reg <= S_DONE;
                     done_reg  <= 1'b1;
                  end else begin
                     out_reg   <= out_reg + 4'd1;
                     valid_reg <= 1'b1;
                  end
               end else begin
                  timer_reg <= timer_reg + TW'(1);
               end
            end
            S_DONE: begin
               if (!mode) begin
                  state_reg <= S_MANUAL;
                  done_reg  <= 1'b0;
                  entry_reg <= 1'b1;
               end else if (key_press) begin
                  state_reg <= S_SWEEP;
                  done_reg  <= 1'b0;
                  entry_reg <= 1'b1;
               end
            end
            default: begin
               state_reg <= S_MANUAL;
               done_reg  <= 1'b0;
               entry_reg <= 1'b1;
            end
         endcase
      end
   end
`else
   assign sweep_done = 1'b0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sw_prev_reg <= '0;
         out_reg     <= '0;
         valid_reg   <= 1'b0;
      end else begin
         sw_prev_reg <= sw_stable;
         valid_reg   <= 1'b0;
         if (sw_changed) begin
            out_reg   <= sw_stable;
            valid_reg <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_switch_input_conditioner.sv
// Scoreboard bench: directed stimulus pushes expected {value, edge} pairs, a monitor checks every abcd_valid strobe.
module tb_switch_input_conditioner;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] sw_in;
   logic       key_step_n;
   logic       mode;
   logic [3:0] abcd_out;
   logic       abcd_valid;
   logic       sweep_done;

   int cyc = 0;
   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [3:0] val;
      int         edge_no;
   } exp_t;

   exp_t sb[$];

   switch_input_conditioner #(
      .DEBOUNCE_CYCLES(4),
      .STEP_CYCLES(8)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .sw_in(sw_in),
      .key_step_n(key_step_n),
      .mode(mode),
      .abcd_out(abcd_out),
      .abcd_valid(abcd_valid),
      .sweep_done(sweep_done)
   );

   always #5 clk = ~clk;

   // cyc equals the number of rising edges seen; read at the falling edge.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, cyc);
      end else begin
         $display("ok   %s: %0d (edge %0d)", name, act, cyc);
      end
   endtask

   task automatic expect_at(input logic [3:0] val, input int edge_no);
      exp_t x;
      x.val     = val;
      x.edge_no = edge_no;
      sb.push_back(x);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic tick_until(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   // Monitor: every strobe must match the oldest outstanding expectation.
   initial begin
      exp_t x;
      forever begin
         @(negedge clk);
         if (abcd_valid === 1'b1) begin
            if (sb.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_valid: abcd_out=%0d at edge %0d, required no strobe", abcd_out, cyc);
            end else begin
               x = sb.pop_front();
               check("strobe_value", int'(abcd_out), int'(x.val));
               check("strobe_edge", cyc, x.edge_no);
            end
         end
      end
   end

   initial begin
      int e;
      int k;
      int x;
      int y;
      rst_n      = 1'b0;
      sw_in      = 4'hF;
      key_step_n = 1'b1;
      mode       = 1'b0;

      for (int i = 0; i < 3; i++) begin
         tick(1);
         check("rst_out", int'(abcd_out), 0);
         check("rst_valid", int'(abcd_valid), 0);
         check("rst_done", int'(sweep_done), 0);
      end
      rst_n = 1'b1;
      expect_at(4'hF, cyc + 7);
      tick(12);

      sw_in = 4'h0;
      expect_at(4'h0, cyc + 7);
      tick(12);
      sw_in = 4'b1010;
      expect_at(4'b1010, cyc + 7);
      tick(12);
      sw_in = 4'h0;
      expect_at(4'h0, cyc + 7);
      tick(12);

      // 3-cycle pulse is rejected; a 4-cycle pulse is just accepted.
      sw_in = 4'b1000;
      tick(3);
      sw_in = 4'h0;
      tick(12);
      check("glitch_out", int'(abcd_out), 0);
      sw_in = 4'b1000;
      expect_at(4'b1000, cyc + 7);
      tick(4);
      sw_in = 4'h0;
      expect_at(4'h0, cyc + 7);
      tick(14);

`ifdef SWITCH_SWEEP_EN
      // Key falls one cycle before mode rises so the press lands at dwell count 3.
      key_step_n = 1'b0;
      tick(1);
      mode = 1'b1;
      e = cyc + 2;
      expect_at(4'd0, e);
      expect_at(4'd1, e + 4);
      for (int v = 2; v < 16; v++) expect_at(4'(v), e + 4 + 8 * (v - 1));
      tick_until(e + 3);
      key_step_n = 1'b1;
      // Press acting on the same edge as the timer expiry that yields value 3.
      tick_until(e + 13);
      key_step_n = 1'b0;
      tick_until(e + 19);
      key_step_n = 1'b1;
      tick_until(e + 123);
      check("done_before_end", int'(sweep_done), 0);
      tick_until(e + 125);
      check("done_at_end", int'(sweep_done), 1);
      check("hold_15", int'(abcd_out), 15);

      // Press in DONE restarts the sweep at 0.
      k = cyc;
      key_step_n = 1'b0;
      expect_at(4'd0, k + 8);
      for (int v = 1; v < 8; v++) expect_at(4'(v), k + 8 + 8 * v);
      tick(6);
      key_step_n = 1'b1;
      sw_in = 4'b0011;
      x = k + 8 + 58;
      tick_until(x);
      check("sweep_index7", int'(abcd_out), 7);
      mode = 1'b0;
      expect_at(4'b0011, x + 2);
      tick_until(x + 4);
      check("done_after_exit", int'(sweep_done), 0);

      // Reset while the sweep sits at index 9.
      tick(2);
      mode = 1'b1;
      y = cyc + 2;
      for (int v = 0; v < 10; v++) expect_at(4'(v), y + 8 * v);
      tick_until(y + 74);
      check("sweep_index9", int'(abcd_out), 9);
      rst_n = 1'b0;
      mode  = 1'b0;
      tick(1);
      check("midrst_out", int'(abcd_out), 0);
      check("midrst_valid", int'(abcd_valid), 0);
      check("midrst_done", int'(sweep_done), 0);
      tick(1);
      rst_n = 1'b1;
      expect_at(4'b0011, cyc + 7);
      tick(14);
      check("manual_after_rst", int'(abcd_out), 3);
`else
      // Manual-only build: mode and key are ignored entirely.
      mode = 1'b1;
      key_step_n = 1'b0;
      tick(10);
      check("nosweep_done", int'(sweep_done), 0);
      sw_in = 4'b0101;
      expect_at(4'b0101, cyc + 7);
      tick(6);
      key_step_n = 1'b1;
      tick(10);
      mode = 1'b0;
      tick(6);
      check("nosweep_out", int'(abcd_out), 5);
      check("nosweep_done2", int'(sweep_done), 0);
`endif

      tick(2);
      check("scoreboard_empty", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/switch_input_conditioner.md
# switch_input_conditioner

Upstream input stage for the four-variable A/B/C/D logic exercise. Synchronizes and debounces the four board switches and a step pushbutton, and presents a clean registered 4-bit vector to the combinational function stage. An optional sweep mode steps the vector through all 16 combinations so the whole truth table can be shown from one board.

## Interface
- `DEBOUNCE_CYCLES`, default 50000: consecutive stable cycles required before a raw input is accepted. Minimum 2.
- `STEP_CYCLES`, default 25000000: sweep dwell time per combination, in cycles. Minimum 2.

Ports:
- `clk`, input, 1: single clock for the block.
- `rst_n`, input, 1: synchronous, active-low reset.
- `sw_in`, input, 4: raw asynchronous switches. Bit 3 is A, bit 2 is B, bit 1 is C, bit 0 is D.
- `key_step_n`, input, 1: raw asynchronous pushbutton, active-low.
- `mode`, input, 1: synchronous. 0 is manual, 1 is sweep.
- `abcd_out`, output, 4: registered vector to the function stage, using the same bit order as `sw_in`.
- `abcd_valid`, output, 1: one-cycle strobe, high in every cycle in which `abcd_out` takes a new value.
- `sweep_done`, output, 1: level signal, high while in the DONE state.

## Operation
- **Synchronizer:** every raw input (4 switches plus the key) passes through a 2-flop synchronizer.
- **Debouncer (per input):**
  - Holds a `stable` bit and a counter.
  - The counter increments each cycle that the synchronized value differs from `stable`.
  - The counter clears whenever they match.
  - When the counter is at `DEBOUNCE_CYCLES-1` and the values still differ, `stable` takes the synchronized value and the counter clears.
- **Key press event:** a key `stable` transition from 1 to 0. A release generates no event.
- **FSM states:** MANUAL, SWEEP, DONE.
- **MANUAL:**
  - When the switch `stable` vector changes, `abcd_out` is loaded with it on the next edge and `abcd_valid` pulses.
  - Key presses are ignored.
  - `mode`=1 moves to SWEEP.
- **SWEEP:**
  - On entry, `abcd_out` is set to 0, `abcd_valid` pulses, and the dwell timer is cleared.
  - The timer counts up to `STEP_CYCLES-1`. Timer expiry or a key press advances `abcd_out` by 1, pulses `abcd_valid` and clears the timer.
  - An advance from 15 does not wrap. It moves to DONE with `abcd_out` held at 15 and no `abcd_valid` pulse.
  - `mode`=0 moves to MANUAL.
- **DONE:**
  - `sweep_done`=1 and `abcd_out` holds.
  - A key press moves to SWEEP, with the same entry action as above.
  - `mode`=0 moves to MANUAL.
- **Entry to MANUAL from SWEEP or DONE:** `abcd_out` is loaded with the current switch `stable` vector on the next edge and `abcd_valid` pulses, even if the value is unchanged.
- **Simultaneous events:**
  - Timer expiry and a key press in the same cycle give exactly one advance.
  - `mode`=0 takes priority over any step in the same cycle.

## Timing
- **Reset values:**
  - `abcd_out`=0, `abcd_valid`=0, `sweep_done`=0, FSM in MANUAL.
  - Switch `stable`=0 and key `stable`=1; all counters 0; synchronizer flops hold the same values as the corresponding `stable` bits.
- **Reset mid-operation:** returns to the reset values on the next edge. An in-progress debounce or sweep is discarded.
- **Debounce latency:** edge 0 is the first edge that samples the new raw value.
  - The synchronized value differs from edge 1.
  - `stable` updates at edge `DEBOUNCE_CYCLES+1`.
  - `abcd_out` and `abcd_valid` update at edge `DEBOUNCE_CYCLES+2`.
- **Glitch rejection:** a raw pulse that lasts fewer than `DEBOUNCE_CYCLES` synchronized cycles produces no output change.
- **Step period:** in SWEEP with no key activity, consecutive `abcd_valid` pulses are exactly `STEP_CYCLES` cycles apart.
- **Mode response:** a change in `mode` sampled at edge k causes the state change at edge k and the output update at edge k+1.
- **Pulse width:** `abcd_valid` is never high for two consecutive cycles caused by the same event.

## Configuration
- **`SWITCH_SWEEP_EN` defined:** the full MANUAL/SWEEP/DONE behaviour above.
- **`SWITCH_SWEEP_EN` undefined:**
  - The FSM, dwell timer and key path are removed, and `mode` and `key_step_n` are ignored.
  - `sweep_done` is tied to 0.
  - The block is manual-only and its manual behaviour is identical to the defined case.

## Test plan
Unless stated otherwise, `DEBOUNCE_CYCLES`=4 and `STEP_CYCLES`=8.
- **Reset:** hold `rst_n`=0 for 3 cycles with `sw_in`=4'b1111, then release. `abcd_out`=0, `abcd_valid`=0 and `sweep_done`=0 during reset; `abcd_out` becomes 4'b1111 with one `abcd_valid` pulse exactly 6 edges after `rst_n` is first sampled 1.
- **Debounce latency:** `sw_in` goes 0 to 4'b1010 just before edge 0. `abcd_out`=4'b1010 with `abcd_valid` pulsing at edge 6 only.
- **Glitch:** `sw_in[3]` high for 3 cycles, then low. No `abcd_valid` pulse and `abcd_out` unchanged.
- **Full sweep:** `mode`=1 and no key activity. `abcd_out` steps 0, 1, …, 15 with 16 `abcd_valid` pulses spaced 8 cycles apart, then `sweep_done`=1 and `abcd_out` holds 15.
- **Key step and coincidence:**
  - A debounced key press at timer count 3 advances immediately and restarts the dwell count.
  - A key press coincident with timer expiry advances by exactly one.
  - A key press in DONE restarts the sweep at 0.
- **Exit and reset mid-sweep:**
  - `mode`=0 at index 7 with `sw_in`=4'b0011: `abcd_out`=4'b0011 and `abcd_valid` pulses one cycle later.
  - `rst_n`=0 at index 9: `abcd_out`=0 and the FSM is back in MANUAL.
